// File: rtl/l4_result_tx.sv
// ---------------------------------------------------------------------------
// l4_result_tx
// Serialises the 36-bit layer-4 accumulated result over an 8N1 UART line.
// The result is zero-extended to 40 bits and sent as five back-to-back
// frames, least significant byte first. After the last frame a one-cycle
// tx_done pulse clears layer 4, and the block then waits for trmt to drop
// so that a still-asserted request cannot start a second transmission.
//
// Optional feature (macro L4_TX_CHECKSUM_EN): when defined, a sixth frame
// carrying the XOR of the five data bytes is sent before tx_done.
//
// Parameters:
//   BAUD_DIV  clock cycles per UART bit (434 = 50 MHz / 115200)
// Ports:
//   clk      clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   trmt     level request: layer-4 result is ready
//   q        36-bit result, sampled once when a transmission starts
//   tx       registered UART serial output, idle high
//   tx_done  one-cycle pulse after the final stop bit
//   busy     high whenever the block is not idle
// ---------------------------------------------------------------------------
module l4_result_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trmt,
  input  logic [35:0] q,
  output logic        tx,
  output logic        tx_done,
  output logic        busy
);

`ifdef L4_TX_CHECKSUM_EN
  localparam int NFRAMES = 6;
  localparam int SR_W    = 48;
`else
  localparam int NFRAMES = 5;
  localparam int SR_W    = 40;
`endif

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [2:0]       byte_cnt;
  logic [SR_W-1:0]  shift_sr;
  logic             baud_last;

`ifdef L4_TX_CHECKSUM_EN
  // XOR of the five transmitted data bytes, top byte zero-extended.
  function automatic logic [7:0] checksum(input logic [35:0] d);
    return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ {4'b0, d[35:32]};
  endfunction
`endif

  // Image loaded into the shift register when a transmission starts.
  function automatic logic [SR_W-1:0] load_image(input logic [35:0] d);
`ifdef L4_TX_CHECKSUM_EN
    return {checksum(d), 4'b0, d};
`else
    return {4'b0, d};
`endif
  endfunction

  assign baud_last = (baud_cnt == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift_sr <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trmt) begin
            shift_sr <= load_image(q);
            byte_cnt <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_sr[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // The register shifts once per data bit, so after eight bits the
        // next byte is already sitting in the low end.
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift_sr <= shift_sr >> 1;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift_sr[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_cnt == 3'(NFRAMES - 1)) begin
              state <= DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DONE: begin
          tx_done <= 1'b1;
          state   <= HOLD;
        end

        // Wait for the request to drop so a held trmt cannot re-trigger.
        HOLD: begin
          if (!trmt) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l4_result_tx.sv
module tb_l4_result_tx;

`ifdef L4_TX_CHECKSUM_EN
  localparam int NFR = 6;
`else
  localparam int NFR = 5;
`endif
  localparam int BD = 4;
  localparam int NS = NFR * 10 * BD + 6;
  localparam int DONE_AT = NFR * 10 * BD + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        trmt;
  logic [35:0] q;
  logic        tx;
  logic        tx_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic tx_s   [0:NS-1];
  logic done_s [0:NS-1];
  logic busy_s [0:NS-1];

  l4_result_tx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .q       (q),
    .tx      (tx),
    .tx_done (tx_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference: byte f of the transmission, from plain arithmetic on q.
  function automatic logic [7:0] exp_byte(input logic [35:0] qv, input int f);
    logic [39:0] w;
    logic [7:0]  x;
    w = {4'b0, qv};
    if (f < 5) return w[f*8 +: 8];
    x = 8'h00;
    for (int i = 0; i < 5; i++) x = x ^ w[i*8 +: 8];
    return x;
  endfunction

  // Decode frame f from the captured trace: {well_formed, byte}.
  function automatic logic [8:0] decode(input int f);
    logic       ok;
    logic [7:0] b;
    logic       v;
    int         base;
    ok = 1'b1;
    b  = 8'h00;
    for (int k = 0; k < 10; k++) begin
      base = f * 10 * BD + k * BD;
      v = tx_s[base];
      for (int j = 1; j < BD; j++) if (tx_s[base + j] !== v) ok = 1'b0;
      if (k == 0 && v !== 1'b0) ok = 1'b0;
      if (k == 9 && v !== 1'b1) ok = 1'b0;
      if (k >= 1 && k <= 8) b[k-1] = v;
    end
    return {ok, b};
  endfunction

  // Start a transmission of qv and record NS samples (sample c is taken
  // just after edge c; edge 0 samples trmt high). Leaves trmt high.
  task automatic capture(input logic [35:0] qv, input bit drop, input bit qchg);
    if (drop) begin
      @(negedge clk);
      trmt = 1'b0;
    end
    @(negedge clk);
    rst  = 1'b0;
    q    = qv;
    trmt = 1'b1;
    @(posedge clk);
    #1;
    tx_s[0] = tx; done_s[0] = tx_done; busy_s[0] = busy;
    for (int c = 1; c < NS; c++) begin
      @(posedge clk);
      #1;
      tx_s[c] = tx; done_s[c] = tx_done; busy_s[c] = busy;
      if (qchg && c == 50) q = 36'h0;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    trmt = 1'b0;
    q    = 36'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({tx, tx_done, busy} !== 3'b100) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d tx/done/busy=%b want 100", i, {tx, tx_done, busy});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({tx, tx_done, busy} !== 3'b100) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d tx/done/busy=%b want 100", i, {tx, tx_done, busy});
      end
    end
  endtask

  task automatic test_basic;
    logic [35:0] qv;
    logic [8:0]  d;
    int          ndone;
    int          at;
    qv = 36'h987654321;
    capture(qv, 1'b1, 1'b0);
    for (int f = 0; f < NFR; f++) begin
      d = decode(f);
      total++;
      if (d !== {1'b1, exp_byte(qv, f)}) begin
        bad++;
        $display("FAIL basic_frame%0d got ok/byte=%h want 1%h", f, d, exp_byte(qv, f));
      end
    end
    ndone = 0; at = -1;
    for (int c = 0; c < NS; c++) if (done_s[c] === 1'b1) begin ndone++; at = c; end
    total++;
    if (ndone != 1 || at != DONE_AT) begin
      bad++;
      $display("FAIL basic_tx_done count=%0d at=%0d want 1 at %0d", ndone, at, DONE_AT);
    end
    ndone = 0;
    for (int c = 0; c < NS; c++) if (busy_s[c] !== 1'b1) ndone++;
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL basic_busy low_samples=%0d want 0", ndone);
    end
  endtask

  task automatic test_hold;
    logic [35:0] qv;
    logic [8:0]  d;
    int          ndone;
    int          at;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({tx, tx_done, busy} !== 3'b101) begin
        bad++;
        $display("FAIL hold cyc=%0d tx/done/busy=%b want 101", i, {tx, tx_done, busy});
      end
    end
    @(negedge clk);
    trmt = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy} !== 2'b10) begin
      bad++;
      $display("FAIL hold_release tx/busy=%b want 10", {tx, busy});
    end
    qv = {$urandom_range(15, 0), $urandom()};
    capture(qv, 1'b0, 1'b0);
    for (int f = 0; f < NFR; f++) begin
      d = decode(f);
      total++;
      if (d !== {1'b1, exp_byte(qv, f)}) begin
        bad++;
        $display("FAIL retrigger_frame%0d got ok/byte=%h want 1%h", f, d, exp_byte(qv, f));
      end
    end
    ndone = 0; at = -1;
    for (int c = 0; c < NS; c++) if (done_s[c] === 1'b1) begin ndone++; at = c; end
    total++;
    if (ndone != 1 || at != DONE_AT) begin
      bad++;
      $display("FAIL retrigger_tx_done count=%0d at=%0d want 1 at %0d", ndone, at, DONE_AT);
    end
  endtask

  task automatic test_q_change;
    logic [35:0] qv;
    logic [8:0]  d;
    qv = 36'h987654321;
    capture(qv, 1'b1, 1'b1);
    for (int f = 0; f < NFR; f++) begin
      d = decode(f);
      total++;
      if (d !== {1'b1, exp_byte(qv, f)}) begin
        bad++;
        $display("FAIL qchange_frame%0d got ok/byte=%h want 1%h", f, d, exp_byte(qv, f));
      end
    end
  endtask

  task automatic test_random;
    logic [35:0] qv;
    logic [8:0]  d;
    int          at;
    for (int r = 0; r < 3; r++) begin
      qv = {$urandom_range(15, 0), $urandom()};
      capture(qv, 1'b1, 1'b0);
      for (int f = 0; f < NFR; f++) begin
        d = decode(f);
        total++;
        if (d !== {1'b1, exp_byte(qv, f)}) begin
          bad++;
          $display("FAIL random%0d_frame%0d got ok/byte=%h want 1%h", r, f, d, exp_byte(qv, f));
        end
      end
      at = -1;
      for (int c = NS - 1; c >= 0; c--) if (done_s[c] === 1'b1) at = c;
      total++;
      if (at != DONE_AT) begin
        bad++;
        $display("FAIL random%0d_tx_done first_at=%0d want %0d", r, at, DONE_AT);
      end
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clk);
    trmt = 1'b0;
    @(negedge clk);
    q    = {$urandom_range(15, 0), $urandom()};
    trmt = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk);
      #1;
      if (tx_done === 1'b1) ndone++;
    end
    @(negedge clk);
    rst  = 1'b1;
    trmt = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({tx, busy} !== 2'b10) begin
      bad++;
      $display("FAIL reset_mid tx/busy=%b want 10", {tx, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NS + 20; i++) begin
      @(posedge clk);
      #1;
      if (tx_done === 1'b1 || tx !== 1'b1 || busy !== 1'b0) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet bad_samples=%0d want 0", ndone);
    end
  endtask

  task automatic test_reset_trmt_high;
    logic [35:0] qv;
    logic [8:0]  d;
    qv = {$urandom_range(15, 0), $urandom()};
    @(negedge clk);
    rst  = 1'b1;
    trmt = 1'b1;
    q    = qv;
    repeat (2) @(posedge clk);
    capture(qv, 1'b0, 1'b0);
    for (int f = 0; f < NFR; f++) begin
      d = decode(f);
      total++;
      if (d !== {1'b1, exp_byte(qv, f)}) begin
        bad++;
        $display("FAIL rst_trmt_frame%0d got ok/byte=%h want 1%h", f, d, exp_byte(qv, f));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_q_change();
    test_random();
    test_reset_mid();
    test_reset_trmt_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l4_result_tx.md
L4_RESULT_TX -- requirements
Module: l4_result_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434: clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port trmt, input, 1 bit: level request from layer 4 that its result is ready.
REQ-005 SHALL have port q, input, 36 bits: layer-4 accumulated result, valid while trmt is high.
REQ-006 SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high.
REQ-007 SHALL have port tx_done, output, 1 bit: one-cycle pulse when the last frame completes; it clears layer 4.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 SHALL implement states IDLE, START, DATA, STOP, DONE and HOLD.
REQ-010 In IDLE with trmt=1, SHALL capture q into a 40-bit shift register zero-extended to {4'b0,q}, clear the byte counter and go to START.
REQ-011 tx SHALL go low on the cycle after the cycle trmt is sampled high in IDLE.
REQ-012 Each bit SHALL last exactly BAUD_DIV cycles, timed by a baud counter running 0..BAUD_DIV-1 and reloaded on every bit boundary.
REQ-013 Each frame SHALL be one start bit (0), then 8 data bits LSB first, then one stop bit (1): START, then DATA with a 3-bit bit counter, then STOP.
REQ-014 Byte order SHALL be q[7:0], q[15:8], q[23:16], q[31:24], {4'b0,q[35:32]}, giving 5 frames.
REQ-015 Frames SHALL be sent back to back with no idle gap: at the end of STOP, if frames remain, go to START for the next byte.
REQ-016 After the final STOP the state SHALL go to DONE; in DONE tx_done=1 for exactly one cycle, then go to HOLD.
REQ-017 HOLD SHALL keep tx=1 and go to IDLE only on a cycle with trmt=0, so a still-high trmt never re-triggers.
REQ-018 Changes on q after capture SHALL be ignored.
REQ-019 trmt deasserting mid-transmission SHALL be ignored; the transmission completes.
REQ-020 tx SHALL be registered and glitch-free.
REQ-021 tx SHALL be 1 in IDLE, DONE and HOLD.

Reset
REQ-022 On rst=1 at a clock edge, SHALL set state=IDLE, tx=1, tx_done=0 and busy=0, and clear all counters and the shift register.
REQ-023 rst SHALL take priority over every other event, including reset mid-frame, which aborts the frame with no tx_done pulse.
REQ-024 After rst deasserts with trmt already high, a new transmission SHALL start per REQ-010.

Configuration
REQ-025 Macro L4_TX_CHECKSUM_EN, when defined, SHALL append a 6th frame carrying the XOR of the 5 data bytes, sent before DONE; 6 frames total.
REQ-026 With L4_TX_CHECKSUM_EN undefined, SHALL send exactly 5 frames and contain no checksum logic.

Verification (BAUD_DIV=4; cycle 0 = edge sampling trmt high)
REQ-027 Hold rst=1 for 3 cycles, then release with trmt=0 -> tx=1, tx_done=0 and busy=0 throughout.
REQ-028 q=36'h987654321 with trmt held high -> bytes 0x21, 0x43, 0x65, 0x87, 0x09 are decoded from tx, each bit 4 cycles wide; tx_done is high only at cycle 201.
REQ-029 Keep trmt high for 20 cycles after tx_done -> tx stays 1 and busy=1 (HOLD); dropping trmt gives busy=0, and raising it again starts a new transmission.
REQ-030 Change q to 36'h0 during byte 1 -> the transmitted bytes are unchanged from REQ-028.
REQ-031 Assert rst during byte 2 -> tx=1 and busy=0 on the next cycle, and no tx_done pulse occurs.
REQ-032 With L4_TX_CHECKSUM_EN defined and the stimulus of REQ-028 -> a 6th byte 0x89 is sent, and tx_done is high at cycle 241.
